nvdla_slcg_hyst_ctrl: RTL and testbench



---
 rtl/nvdla_slcg_pkg.sv | 14 +
 rtl/nvdla_slcg_icg.sv | 18 +
 rtl/nvdla_slcg_hyst_ctrl.sv | 107 ++++++++++
 tb/tb_nvdla_slcg_hyst_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nvdla_slcg_pkg.sv
// Shared types for the NVDLA second-level clock gate.
// State encoding and statistics counter width.
package nvdla_slcg_pkg;

  localparam int SLCG_STATE_W = 2;
  localparam int SLCG_STAT_W  = 32;

  typedef enum logic [SLCG_STATE_W-1:0] {
    SLCG_RUN   = 2'd0,
    SLCG_DRAIN = 2'd1,
    SLCG_OFF   = 2'd2
  } slcg_state_e;

endpackage

// File: rtl/nvdla_slcg_icg.sv
// Behavioural latch-based clock gate.
// Replaced by the library ICG cell at synthesis.
module nvdla_slcg_icg (
  input  logic clk_i,
  input  logic en_i,
  output logic gclk_o
);

  logic en_lat_q;

  // Transparent while the clock is low, so enable edges never clip a pulse.
  always_latch begin
    if (!clk_i) en_lat_q <= en_i;
  end

  assign gclk_o = clk_i & en_lat_q;

endmodule

// File: rtl/nvdla_slcg_hyst_ctrl.sv
// SLCG controller with idle hysteresis and latch-based gate.
// Optional gated-cycle statistics under NVDLA_SLCG_STATS_EN.
module nvdla_slcg_hyst_ctrl
  import nvdla_slcg_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int HYST_W  = 4
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [NUM_SRC-1:0]      slcg_en_src,
  input  logic [HYST_W-1:0]       cfg_hyst_cycles,
  input  logic                    dla_clk_ovr_on_sync,
  input  logic                    global_clk_ovr_on_sync,
  input  logic                    tmc2slcg_disable_clock_gating,
  output logic                    nvdla_core_gated_clk,
  output logic                    slcg_clk_en,
  output logic [SLCG_STATE_W-1:0] slcg_state,
  output logic [SLCG_STAT_W-1:0]  slcg_gated_cycles
);

  slcg_state_e       state_q, state_d;
  logic [HYST_W-1:0] cnt_q, cnt_d;
  logic              req;
  logic              ovr;
  logic              en_reg;

  assign req = |slcg_en_src;
  assign ovr = dla_clk_ovr_on_sync
             | global_clk_ovr_on_sync
             | tmc2slcg_disable_clock_gating;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= SLCG_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SLCG_RUN: begin
        if (!req) begin
          if (cfg_hyst_cycles == '0) begin
            state_d = SLCG_OFF;
          end else begin
            state_d = SLCG_DRAIN;
            cnt_d   = HYST_W'(1);
          end
        end
      end
      SLCG_DRAIN: begin
        if (req) begin
          state_d = SLCG_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= cfg_hyst_cycles) begin
          state_d = SLCG_OFF;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + HYST_W'(1);
        end
      end
      SLCG_OFF: begin
        if (req) begin
          state_d = SLCG_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SLCG_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Overrides bypass the FSM so they act within the current low phase.
  assign en_reg      = (state_q != SLCG_OFF);
  assign slcg_clk_en = en_reg | ovr;
  assign slcg_state  = state_q;

  nvdla_slcg_icg u_icg (
    .clk_i  (nvdla_core_clk),
    .en_i   (slcg_clk_en),
    .gclk_o (nvdla_core_gated_clk)
  );

`ifdef NVDLA_SLCG_STATS_EN
  logic [SLCG_STAT_W-1:0] stat_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stat_q <= '0;
    end else if (!slcg_clk_en && stat_q != '1) begin
      stat_q <= stat_q + SLCG_STAT_W'(1);
    end
  end

  assign slcg_gated_cycles = stat_q;
`else
  assign slcg_gated_cycles = '0;
`endif

endmodule

// File: tb/tb_nvdla_slcg_hyst_ctrl.sv
// Directed bench for nvdla_slcg_hyst_ctrl.
// Stats checks follow NVDLA_SLCG_STATS_EN.
module tb_nvdla_slcg_hyst_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  src;
  logic [3:0]  cfg;
  logic        dla_ovr;
  logic        glb_ovr;
  logic        tmc_dis;
  logic        gclk;
  logic        clk_en;
  logic [1:0]  st;
  logic [31:0] gated_cyc;

  int n_chk;
  int n_fail;
  int pulses;
  int glitch;
  int unsigned stat0;
  realtime t_rise;

  nvdla_slcg_hyst_ctrl #(.NUM_SRC(2), .HYST_W(4)) dut (
    .nvdla_core_clk               (clk),
    .nvdla_core_rstn              (rst_n),
    .slcg_en_src                  (src),
    .cfg_hyst_cycles              (cfg),
    .dla_clk_ovr_on_sync          (dla_ovr),
    .global_clk_ovr_on_sync       (glb_ovr),
    .tmc2slcg_disable_clock_gating(tmc_dis),
    .nvdla_core_gated_clk         (gclk),
    .slcg_clk_en                  (clk_en),
    .slcg_state                   (st),
    .slcg_gated_cycles            (gated_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge gclk) begin
    pulses++;
    t_rise = $realtime;
    if (clk !== 1'b1) glitch++;
  end

  always @(negedge gclk) begin
    if ($realtime - t_rise < 5.0) glitch++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; pulses = 0; glitch = 0;
    t_rise = 0.0;
    rst_n = 1'b1; src = 2'b00; cfg = 4'd3;
    dla_ovr = 1'b0; glb_ovr = 1'b0; tmc_dis = 1'b0;
    #2 rst_n = 1'b0;
    pulses = 0;
    step(3);
    chk("rst_pulses", pulses, 3);
    chk("rst_state", st, 0);
    chk("rst_en", clk_en, 1);
    chk("rst_stat", gated_cyc, 0);

    // release: DRAIN after edge 1, OFF after edge 4
    rst_n = 1'b1;
    step(1);
    chk("drain_e1", st, 1);
    step(2);
    chk("drain_e3", st, 1);
    step(1);
    chk("off_e4", st, 2);
    chk("off_en", clk_en, 0);
    pulses = 0;
    step(5);
    chk("off_nopulse", pulses, 0);
`ifdef NVDLA_SLCG_STATS_EN
    chk("stat_off", gated_cyc, 5);
`else
    chk("stat_tied0", gated_cyc, 0);
`endif

    // drain interrupted by src[1] at cnt=2
    src = 2'b01;
    step(1);
    chk("wake_run", st, 0);
    src = 2'b00;
    step(2);
    chk("drain_cnt2", st, 1);
    chk("cnt2", dut.cnt_q, 2);
    src = 2'b10;
    pulses = 0;
    step(1);
    chk("abort_run", st, 0);
    chk("abort_cnt", dut.cnt_q, 0);
    step(2);
    chk("abort_pulses", pulses, 3);

    // cfg=0: OFF after one idle edge, one lost cycle on wake
    cfg = 4'd0; src = 2'b00;
    step(1);
    chk("cfg0_off", st, 2);
    pulses = 0;
    step(2);
    chk("cfg0_nopulse", pulses, 0);
    src = 2'b01;
    step(1);
    chk("cfg0_wake_st", st, 0);
    chk("cfg0_lost", pulses, 0);
    step(1);
    chk("cfg0_first", pulses, 1);

    // overrides while OFF
    src = 2'b00;
    step(1);
    chk("ovr_pre_off", st, 2);
    glb_ovr = 1'b1;
    #1 chk("glb_en", clk_en, 1);
    pulses = 0;
    step(5);
    chk("glb_pulses", pulses, 5);
    chk("glb_state", st, 2);
    glb_ovr = 1'b0;
    pulses = 0;
    step(3);
    chk("glb_after", pulses, 0);
    tmc_dis = 1'b1;
    pulses = 0;
    step(5);
    chk("tmc_pulses", pulses, 5);
    chk("tmc_state", st, 2);
    tmc_dis = 1'b0;
    dla_ovr = 1'b1;
    #1 chk("dla_en", clk_en, 1);
    step(1);
    dla_ovr = 1'b0;
    #1 chk("dla_off_en", clk_en, 0);

    // statistics
    cfg = 4'd2;
    step(1);
`ifdef NVDLA_SLCG_STATS_EN
    stat0 = gated_cyc;
    step(10);
    chk("stat_10", gated_cyc, stat0 + 10);
    force dut.stat_q = 32'hFFFF_FFFD;
    step(1);
    release dut.stat_q;
    step(5);
    chk("stat_sat", gated_cyc, 32'hFFFF_FFFF);
`else
    step(10);
    chk("stat_tied0b", gated_cyc, 0);
`endif

    // async reset mid-OFF
    chk("pre_rst_off", st, 2);
    #2 rst_n = 1'b0;
    #1 chk("arst_state", st, 0);
    chk("arst_en", clk_en, 1);
    chk("arst_stat", gated_cyc, 0);
    pulses = 0;
    step(1);
    chk("arst_resume", pulses, 1);
    rst_n = 1'b1;
    step(2);
    chk("glitch", glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
